// File: rtl/msrv32_dmem_access_ctrl_if.sv
// Data-memory access bundle: execute-stage request, AHB-Lite-style data bus
// and the one-cycle completion response, grouped for the access controller.
interface msrv32_dmem_access_ctrl_if;
  logic        req_valid_in;
  logic        req_write_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [3:0]  req_mask_in;
  logic        req_ready_out;

  logic        ahb_ready_in;
  logic        ahb_resp_in;
  logic [31:0] ahb_rdata_in;
  logic [1:0]  ahb_htrans_out;
  logic [31:0] ahb_haddr_out;
  logic        ahb_hwrite_out;
  logic [31:0] ahb_hwdata_out;
  logic [3:0]  ahb_hmask_out;

  logic        rsp_valid_out;
  logic [31:0] rsp_rdata_out;
  logic        rsp_err_out;

  // Controller side.
  modport slave (
    input  req_valid_in, req_write_in, req_addr_in, req_wdata_in, req_mask_in,
    output req_ready_out,
    input  ahb_ready_in, ahb_resp_in, ahb_rdata_in,
    output ahb_htrans_out, ahb_haddr_out, ahb_hwrite_out, ahb_hwdata_out, ahb_hmask_out,
    output rsp_valid_out, rsp_rdata_out, rsp_err_out
  );

  // Requester plus bus environment side.
  modport master (
    output req_valid_in, req_write_in, req_addr_in, req_wdata_in, req_mask_in,
    input  req_ready_out,
    output ahb_ready_in, ahb_resp_in, ahb_rdata_in,
    input  ahb_htrans_out, ahb_haddr_out, ahb_hwrite_out, ahb_hwdata_out, ahb_hmask_out,
    input  rsp_valid_out, rsp_rdata_out, rsp_err_out
  );
endinterface

// File: rtl/msrv32_dmem_access_ctrl.sv
// Data-memory access controller: one load/store at a time, address phase
// followed by data phase on the AHB-Lite-style bus, registered one-cycle
// response, and a wait-state watchdog that aborts hung transfers.
module msrv32_dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                        ms_riscv32_mp_clk_in,
  input  logic                        ms_riscv32_mp_rst_in,
  msrv32_dmem_access_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [31:0]      ADDR_MASK = 32'hFFFF_FFFC;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // A-regs: the request accepted for the upcoming address phase.
  logic [31:0]        a_addr_q, a_addr_d;
  logic               a_write_q, a_write_d;
  logic [31:0]        a_wdata_q, a_wdata_d;
  logic [3:0]         a_mask_q, a_mask_d;
  // D-regs: the transfer currently in its data phase.
  logic [31:0]        d_addr_q, d_addr_d;
  logic               d_write_q, d_write_d;
  logic [31:0]        d_wdata_q, d_wdata_d;
  logic [3:0]         d_mask_q, d_mask_d;
  // Registered response.
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic               ready_s;
  logic               accept_s;
  logic               timeout_s;

  // Handshake decode: when a request may be taken and when the watchdog fires.
  always_comb begin
    ready_s = 1'b0;
    if (ms_riscv32_mp_rst_in) begin
      ready_s = 1'b0;
    end else if (state_q == S_IDLE) begin
      ready_s = 1'b1;
    end else if (state_q == S_DATA) begin
      // A timeout needs ahb_ready_in low, so it can never coincide with this.
      ready_s = bus.ahb_ready_in;
    end else begin
      ready_s = 1'b0;
    end
    accept_s  = bus.req_valid_in & ready_s;
    timeout_s = (state_q != S_IDLE) & ~bus.ahb_ready_in & (cnt_q == CNT_LAST);
  end

  // Next-state and datapath-register update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_wdata_d   = a_wdata_q;
    a_mask_d    = a_mask_q;
    d_addr_d    = d_addr_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    d_mask_d    = d_mask_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_addr_d  = bus.req_addr_in;
          a_write_d = bus.req_write_in;
          a_wdata_d = bus.req_wdata_in;
          a_mask_d  = bus.req_mask_in;
          cnt_d     = CNT_ZERO;
          state_d   = S_ADDR;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ADDR: begin
        if (bus.ahb_ready_in) begin
          d_addr_d  = a_addr_q;
          d_write_d = a_write_q;
          d_wdata_d = a_wdata_q;
          d_mask_d  = a_mask_q;
          cnt_d     = CNT_ZERO;
          state_d   = S_DATA;
        end else if (timeout_s) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
          cnt_d       = CNT_ZERO;
          state_d     = S_IDLE;
        end else begin
          cnt_d       = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bus.ahb_ready_in) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.ahb_resp_in;
          rsp_rdata_d = d_write_q ? 32'h0000_0000 : bus.ahb_rdata_in;
          if (accept_s) begin
            // Chain straight into the next address phase, no idle bubble.
            a_addr_d  = bus.req_addr_in;
            a_write_d = bus.req_write_in;
            a_wdata_d = bus.req_wdata_in;
            a_mask_d  = bus.req_mask_in;
            cnt_d     = CNT_ZERO;
            state_d   = S_ADDR;
          end else begin
            state_d   = S_IDLE;
          end
        end else if (timeout_s) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
          cnt_d       = CNT_ZERO;
          state_d     = S_IDLE;
        end else begin
          cnt_d       = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; drops any in-flight transfer.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      a_addr_q    <= 32'h0000_0000;
      a_write_q   <= 1'b0;
      a_wdata_q   <= 32'h0000_0000;
      a_mask_q    <= 4'b0000;
      d_addr_q    <= 32'h0000_0000;
      d_write_q   <= 1'b0;
      d_wdata_q   <= 32'h0000_0000;
      d_mask_q    <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_wdata_q   <= a_wdata_d;
      a_mask_q    <= a_mask_d;
      d_addr_q    <= d_addr_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      d_mask_q    <= d_mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Bus and response outputs decoded from the current state and registers.
  always_comb begin
    bus.req_ready_out  = ready_s;
    bus.ahb_htrans_out = 2'b00;
    bus.ahb_haddr_out  = d_addr_q & ADDR_MASK;
    bus.ahb_hwrite_out = d_write_q;
    bus.ahb_hwdata_out = d_wdata_q;
    bus.ahb_hmask_out  = 4'b0000;
    case (state_q)
      S_ADDR: begin
        bus.ahb_htrans_out = 2'b10;
        bus.ahb_haddr_out  = a_addr_q & ADDR_MASK;
        bus.ahb_hwrite_out = a_write_q;
      end
      S_DATA: begin
        bus.ahb_hmask_out  = d_write_q ? d_mask_q : 4'b0000;
      end
      default: begin
        bus.ahb_htrans_out = 2'b00;
      end
    endcase
    bus.rsp_valid_out = rsp_valid_q;
    bus.rsp_err_out   = rsp_err_q;
    bus.rsp_rdata_out = rsp_rdata_q;
  end

endmodule
